// File: rtl/vert_col_scheduler.sv
// Column sequencer for one mac_unit_Vert_8: issues NUM_COLS column descriptors to the MAC in order,
// then sums the MAC's shifted column results into a signed group sum that is presented on a valid/ready port.
module vert_col_scheduler #(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 8,
    parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH),
    parameter int NUM_COLS      = 8,
    parameter int RESULT_WIDTH  = 3 * DATA_WIDTH,
    parameter int ACC_WIDTH     = DATA_WIDTH + 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic                                    desc_valid,
    output logic                                    desc_ready,
    input  logic [VEC_LENGTH/2*MUX_SEL_WIDTH-1:0]   desc_sel,
    input  logic [VEC_LENGTH/2-1:0]                 desc_val,
    input  logic                                    desc_skip_zero,
    output logic                                    mac_en,
    output logic [VEC_LENGTH/2*MUX_SEL_WIDTH-1:0]   mac_act_sel,
    output logic [VEC_LENGTH/2-1:0]                 mac_act_val,
    output logic [2:0]                              mac_column_idx,
    output logic                                    mac_is_msb,
    output logic                                    mac_skip_zero,
    input  logic [RESULT_WIDTH-1:0]                 mac_result,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [ACC_WIDTH-1:0]                    out_acc,
    output logic                                    busy
);

    localparam int CNT_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     col_cnt;
    logic [ACC_WIDTH-1:0] acc;
    logic                 res_v;
    logic                 last_col;

    assign last_col   = (col_cnt == CNT_W'(NUM_COLS - 1));
    assign desc_ready = (state == RUN);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign out_acc    = acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            col_cnt        <= '0;
            acc            <= '0;
            res_v          <= 1'b0;
            mac_en         <= 1'b0;
            mac_act_sel    <= '0;
            mac_act_val    <= '0;
            mac_column_idx <= '0;
            mac_is_msb     <= 1'b0;
            mac_skip_zero  <= 1'b0;
        end else begin
            mac_en <= 1'b0;
            res_v  <= mac_en;
            // MAC result is valid the cycle after mac_en; MSB column arrives pre-negated.
            if (res_v) begin
                acc <= acc + ACC_WIDTH'($signed(mac_result));
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= '0;
                        col_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (desc_valid) begin
                        mac_en         <= 1'b1;
                        mac_act_sel    <= desc_sel;
                        mac_act_val    <= desc_val;
                        mac_skip_zero  <= desc_skip_zero;
                        mac_column_idx <= 3'(col_cnt);
                        mac_is_msb     <= last_col;
                        col_cnt        <= col_cnt + CNT_W'(1);
                        if (last_col) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!mac_en && !res_v) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
